// File: rtl/mailbox_pkg.sv
// Shared register map, STATUS layout and FSM state type for the bus mailbox responder.
package mailbox_pkg;

  localparam logic [1:0] TX_DATA_OFS = 2'd0;
  localparam logic [1:0] RX_DATA_OFS = 2'd1;
  localparam logic [1:0] STATUS_OFS  = 2'd2;
  localparam logic [1:0] IRQ_EN_OFS  = 2'd3;

  localparam int ST_TX_FULL  = 0;
  localparam int ST_TX_EMPTY = 1;
  localparam int ST_RX_EMPTY = 2;
  localparam int ST_RX_FULL  = 3;
  localparam int ST_TX_OVF   = 4;
  localparam int ST_RX_UDF   = 5;

  typedef struct packed {
    logic [7:0] rsvd_hi;
    logic [7:0] tx_count;
    logic [7:0] rx_count;
    logic [1:0] rsvd_lo;
    logic       rx_udf;
    logic       tx_ovf;
    logic       rx_full;
    logic       rx_empty;
    logic       tx_empty;
    logic       tx_full;
  } status_t;

  typedef enum logic {IDLE, HOLD} hold_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO; storage is not reset, only pointers and count.
module sync_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16,
  localparam int AW        = $clog2(DEPTH),
  localparam int CW        = AW + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] head,
  output logic                  full,
  output logic                  empty,
  output logic [CW-1:0]         count
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/bus_mailbox_responder.sv
// CPU-facing TX/RX mailbox pair with STATUS/IRQ registers.
// Define BUS_MAILBOX_BLOCKING_EN to stall full-FIFO TX writes in a hold register instead of dropping them.
module bus_mailbox_responder
  import mailbox_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h0000_9000,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    DEPTH      = 16
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic [ADDR_WIDTH-1:0] address_i,
  input  logic                  we_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  irq_o,
  output logic                  busy_o,
  output logic [DATA_WIDTH-1:0] tx_data_o,
  output logic                  tx_valid_o,
  input  logic                  tx_ready_i,
  input  logic [DATA_WIDTH-1:0] rx_data_i,
  input  logic                  rx_valid_i,
  output logic                  rx_ready_o
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic                  hit;
  logic [1:0]            ofs;
  logic                  busy;
  logic                  bus_wr;
  logic                  tx_wr, rx_wr, st_wr, ie_wr;
  logic                  tx_push, tx_pop, tx_full, tx_empty, tx_drop, tx_ovf_set;
  logic [DATA_WIDTH-1:0] tx_push_data;
  logic [CW-1:0]         tx_count, tx_count_nxt;
  logic                  rx_push, rx_pop, rx_full, rx_empty;
  logic [DATA_WIDTH-1:0] rx_head;
  logic [CW-1:0]         rx_count, rx_count_nxt;
  logic                  tx_ovf, tx_ovf_nxt, rx_udf, rx_udf_nxt;
  logic [1:0]            irq_en, irq_en_nxt;
  logic                  irq_nxt;
  status_t               status;
  logic [DATA_WIDTH-1:0] rdata_nxt;
  logic                  addr_unused;

  assign addr_unused = &{1'b0, address_i[1:0]};

  assign hit    = (address_i[ADDR_WIDTH-1:4] == BASE_ADDR[ADDR_WIDTH-1:4]);
  assign ofs    = address_i[3:2];
  assign bus_wr = we_i & hit & ~busy;
  assign tx_wr  = bus_wr & (ofs == TX_DATA_OFS);
  assign rx_wr  = bus_wr & (ofs == RX_DATA_OFS);
  assign st_wr  = bus_wr & (ofs == STATUS_OFS);
  assign ie_wr  = bus_wr & (ofs == IRQ_EN_OFS);

  assign tx_valid_o = ~tx_empty;
  assign tx_pop     = tx_valid_o & tx_ready_i;
  // A pop in the same cycle frees the slot a full-FIFO write needs.
  assign tx_drop    = tx_wr & tx_full & ~tx_pop;

  assign rx_ready_o = ~rx_full;
  assign rx_push    = rx_valid_i & rx_ready_o;
  assign rx_pop     = rx_wr & ~rx_empty;

`ifdef BUS_MAILBOX_BLOCKING_EN
  hold_state_e           state, state_nxt;
  logic [DATA_WIDTH-1:0] hold_data;

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) state <= IDLE;
    else          state <= state_nxt;
  end

  always_ff @(posedge clk_i) begin
    if (tx_drop) hold_data <= data_i;
  end

  always_comb begin
    state_nxt    = state;
    tx_push      = 1'b0;
    tx_push_data = data_i;
    case (state)
      IDLE: begin
        if (tx_drop) state_nxt = HOLD;
        else         tx_push   = tx_wr;
      end
      HOLD: begin
        if (tx_pop) begin
          tx_push      = 1'b1;
          tx_push_data = hold_data;
          state_nxt    = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy       = (state == HOLD);
  assign tx_ovf_set = 1'b0;
`else
  assign busy         = 1'b0;
  assign tx_push      = tx_wr & ~tx_drop;
  assign tx_push_data = data_i;
  assign tx_ovf_set   = tx_drop;
`endif

  assign busy_o = busy;

  sync_fifo #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_tx_fifo (
    .clk   (clk_i),
    .rst_n (reset_i),
    .push  (tx_push),
    .pop   (tx_pop),
    .din   (tx_push_data),
    .head  (tx_data_o),
    .full  (tx_full),
    .empty (tx_empty),
    .count (tx_count)
  );

  sync_fifo #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_rx_fifo (
    .clk   (clk_i),
    .rst_n (reset_i),
    .push  (rx_push),
    .pop   (rx_pop),
    .din   (rx_data_i),
    .head  (rx_head),
    .full  (rx_full),
    .empty (rx_empty),
    .count (rx_count)
  );

  // Sticky flags: a set in the same cycle as a write-1-clear wins.
  assign tx_ovf_nxt = (tx_ovf & ~(st_wr & data_i[ST_TX_OVF])) | tx_ovf_set;
  assign rx_udf_nxt = (rx_udf & ~(st_wr & data_i[ST_RX_UDF])) | (rx_wr & rx_empty);
  assign irq_en_nxt = ie_wr ? data_i[1:0] : irq_en;

  assign tx_count_nxt = tx_count + CW'(tx_push) - CW'(tx_pop);
  assign rx_count_nxt = rx_count + CW'(rx_push) - CW'(rx_pop);
  assign irq_nxt      = (irq_en_nxt[0] & (rx_count_nxt != '0)) |
                        (irq_en_nxt[1] & (tx_count_nxt == '0));

  always_comb begin
    status          = '0;
    status.tx_full  = tx_full;
    status.tx_empty = tx_empty;
    status.rx_empty = rx_empty;
    status.rx_full  = rx_full;
    status.tx_ovf   = tx_ovf;
    status.rx_udf   = rx_udf;
    status.rx_count = 8'(rx_count);
    status.tx_count = 8'(tx_count);
  end

  always_comb begin
    rdata_nxt = '0;
    if (hit) begin
      case (ofs)
        RX_DATA_OFS: if (!rx_empty) rdata_nxt = rx_head;
        STATUS_OFS:  rdata_nxt = DATA_WIDTH'(status);
        IRQ_EN_OFS:  rdata_nxt = DATA_WIDTH'(irq_en);
        default:     rdata_nxt = '0;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      rdata_o <= '0;
      irq_o   <= 1'b0;
      tx_ovf  <= 1'b0;
      rx_udf  <= 1'b0;
      irq_en  <= 2'b00;
    end else begin
      rdata_o <= rdata_nxt;
      irq_o   <= irq_nxt;
      tx_ovf  <= tx_ovf_nxt;
      rx_udf  <= rx_udf_nxt;
      irq_en  <= irq_en_nxt;
    end
  end

endmodule

// File: tb/tb_bus_mailbox_responder.sv
// Directed-vector bench for bus_mailbox_responder; follows BUS_MAILBOX_BLOCKING_EN when defined.
module tb_bus_mailbox_responder;

  localparam logic [31:0] BASE    = 32'h0000_9000;
  localparam logic [31:0] A_TX    = BASE + 32'h0;
  localparam logic [31:0] A_RX    = BASE + 32'h4;
  localparam logic [31:0] A_ST    = BASE + 32'h8;
  localparam logic [31:0] A_IE    = BASE + 32'hC;

  logic        clk = 1'b0;
  logic        reset_i = 1'b0;
  logic [31:0] address_i = '0;
  logic        we_i = 1'b0;
  logic [31:0] data_i = '0;
  logic [31:0] rdata_o;
  logic        irq_o, busy_o;
  logic [31:0] tx_data_o;
  logic        tx_valid_o;
  logic        tx_ready_i = 1'b0;
  logic [31:0] rx_data_i = '0;
  logic        rx_valid_i = 1'b0;
  logic        rx_ready_o;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] rd;

  always #5 clk = ~clk;

  bus_mailbox_responder dut (
    .clk_i      (clk),
    .reset_i    (reset_i),
    .address_i  (address_i),
    .we_i       (we_i),
    .data_i     (data_i),
    .rdata_o    (rdata_o),
    .irq_o      (irq_o),
    .busy_o     (busy_o),
    .tx_data_o  (tx_data_o),
    .tx_valid_o (tx_valid_o),
    .tx_ready_i (tx_ready_i),
    .rx_data_i  (rx_data_i),
    .rx_valid_i (rx_valid_i),
    .rx_ready_o (rx_ready_o)
  );

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic bus_write(input logic [31:0] addr, input logic [31:0] wdata);
    address_i = addr;
    data_i    = wdata;
    we_i      = 1'b1;
    @(posedge clk); #1;
    we_i      = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] addr, output logic [31:0] value);
    address_i = addr;
    we_i      = 1'b0;
    @(posedge clk); #1;
    value = rdata_o;
  endtask

  task automatic rx_send(input logic [31:0] word);
    rx_data_i  = word;
    rx_valid_i = 1'b1;
    @(posedge clk); #1;
    rx_valid_i = 1'b0;
  endtask

  initial begin
    // Reset and idle state
    repeat (3) @(posedge clk);
    #1 reset_i = 1'b1;
    check_vec("rst_rx_ready", rx_ready_o, 1);
    check_vec("rst_tx_valid", tx_valid_o, 0);
    check_vec("rst_busy", busy_o, 0);
    check_vec("rst_irq", irq_o, 0);
    check_vec("rst_rdata", rdata_o, 0);
    bus_read(A_ST, rd);
    check_vec("rst_status", rd, 32'h0000_0006);
    bus_read(32'h0000_A008, rd);
    check_vec("miss_read", rd, 32'h0);

    // Two TX words, then drain in order
    bus_write(A_TX, 32'hA5A5_0001);
    bus_write(A_TX, 32'hA5A5_0002);
    bus_read(A_ST, rd);
    check_vec("tx2_status", rd, 32'h0002_0004);
    bus_read(A_TX, rd);
    check_vec("tx_data_read0", rd, 32'h0);
    check_vec("tx2_valid", tx_valid_o, 1);
    tx_ready_i = 1'b1;
    check_vec("tx2_head0", tx_data_o, 32'hA5A5_0001);
    @(posedge clk); #1;
    check_vec("tx2_head1", tx_data_o, 32'hA5A5_0002);
    @(posedge clk); #1;
    tx_ready_i = 1'b0;
    check_vec("tx2_drained", tx_valid_o, 0);
    bus_read(A_ST, rd);
    check_vec("tx2_status_end", rd, 32'h0000_0006);

    // Overfill TX with 17 words
    for (int i = 0; i < 17; i++) bus_write(A_TX, 32'h100 + i);
`ifdef BUS_MAILBOX_BLOCKING_EN
    check_vec("ovf_busy", busy_o, 1);
    bus_read(A_ST, rd);
    check_vec("ovf_status_blk", rd, 32'h0010_0005);
    bus_write(A_TX, 32'hDEAD_BEEF);
    check_vec("ovf_busy_hold", busy_o, 1);
    tx_ready_i = 1'b1;
    @(posedge clk); #1;
    tx_ready_i = 1'b0;
    check_vec("ovf_busy_drop", busy_o, 0);
    bus_read(A_ST, rd);
    check_vec("ovf_status_after_pop", rd, 32'h0010_0005);
    tx_ready_i = 1'b1;
    for (int i = 1; i < 17; i++) begin
      check_vec("ovf_drain_blk", tx_data_o, 32'h100 + i);
      @(posedge clk); #1;
    end
`else
    check_vec("ovf_busy", busy_o, 0);
    bus_read(A_ST, rd);
    check_vec("ovf_status", rd, 32'h0010_0015);
    bus_write(A_ST, 32'h10);
    bus_read(A_ST, rd);
    check_vec("ovf_clear", rd, 32'h0010_0005);
    tx_ready_i = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check_vec("ovf_drain", tx_data_o, 32'h100 + i);
      @(posedge clk); #1;
    end
`endif
    tx_ready_i = 1'b0;
    check_vec("ovf_drained", tx_valid_o, 0);

    // RX path and underflow
    rx_send(32'h11);
    rx_send(32'h22);
    rx_send(32'h33);
    bus_read(A_RX, rd);
    check_vec("rx_head0", rd, 32'h11);
    bus_read(A_ST, rd);
    check_vec("rx_status3", rd, 32'h0000_0302);
    bus_write(A_RX, 32'h0);
    bus_read(A_RX, rd);
    check_vec("rx_head1", rd, 32'h22);
    for (int i = 0; i < 3; i++) bus_write(A_RX, 32'h0);
    bus_read(A_RX, rd);
    check_vec("rx_empty_read", rd, 32'h0);
    bus_read(A_ST, rd);
    check_vec("rx_udf_status", rd, 32'h0000_0026);
    bus_write(A_ST, 32'h20);
    bus_read(A_ST, rd);
    check_vec("rx_udf_clear", rd, 32'h0000_0006);

    // Interrupt generation
    bus_write(A_IE, 32'h1);
    check_vec("irq_rx_empty", irq_o, 0);
    bus_read(A_IE, rd);
    check_vec("irq_en_read", rd, 32'h1);
    rx_send(32'h44);
    check_vec("irq_rx_set", irq_o, 1);
    bus_write(A_RX, 32'h0);
    check_vec("irq_rx_clear", irq_o, 0);
    bus_write(A_IE, 32'h2);
    check_vec("irq_tx_empty", irq_o, 1);
    bus_write(A_IE, 32'h0);
    check_vec("irq_off", irq_o, 0);

    // Asynchronous reset mid-stream
    for (int i = 0; i < 5; i++) bus_write(A_TX, 32'h200 + i);
    rx_send(32'h55);
    rx_send(32'h66);
    rx_send(32'h77);
    bus_write(A_IE, 32'h1);
    bus_read(A_ST, rd);
    check_vec("pre_rst_status", rd, 32'h0005_0300);
    check_vec("pre_rst_irq", irq_o, 1);
    #3 reset_i = 1'b0;
    #1;
    check_vec("arst_rdata", rdata_o, 0);
    check_vec("arst_irq", irq_o, 0);
    check_vec("arst_tx_valid", tx_valid_o, 0);
    check_vec("arst_rx_ready", rx_ready_o, 1);
    check_vec("arst_busy", busy_o, 0);
    @(posedge clk); @(posedge clk);
    #2 reset_i = 1'b1;
    bus_read(A_ST, rd);
    check_vec("post_rst_status", rd, 32'h0000_0006);
    bus_read(A_IE, rd);
    check_vec("post_rst_irq_en", rd, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
